// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: mdop encodings,
// which are also used by the E-stage controller and the D-stage hazard unit.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDOP_NONE  = 4'd0,
    MDOP_MULT  = 4'd1,
    MDOP_MULTU = 4'd2,
    MDOP_DIV   = 4'd3,
    MDOP_DIVU  = 4'd4,
    MDOP_MFHI  = 4'd5,
    MDOP_MFLO  = 4'd6,
    MDOP_MTHI  = 4'd7,
    MDOP_MTLO  = 4'd8
  } mdop_e;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
           (op == MDOP_DIV)  || (op == MDOP_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, computes the result at start
// and commits it after a fixed busy period so hazard logic can stall on busy.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDout
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      temp_hi_q, temp_hi_d;
  logic [31:0]      temp_lo_q, temp_lo_d;
  logic             div0_q, div0_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] quo_s, rem_s, quo_u, rem_u;
  logic               accept;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // INT_MIN / -1 overflows; the architectural answer is quotient INT_MIN, remainder 0.
  always_comb begin
    quo_s = '0;
    rem_s = '0;
    quo_u = '0;
    rem_u = '0;
    if (B != 32'd0) begin
      quo_u = A / B;
      rem_u = A % B;
      if (A == INT_MIN && B == 32'hFFFF_FFFF) begin
        quo_s = INT_MIN;
        rem_s = '0;
      end else begin
        quo_s = $signed(A) / $signed(B);
        rem_s = $signed(A) % $signed(B);
      end
    end
  end

  assign busy   = (cnt_q != '0);
  assign accept = start && !busy && is_muldiv(mdop);

  // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    cnt_d     = cnt_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (accept) begin
      cnt_d  = is_div(mdop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      div0_d = is_div(mdop) && (B == 32'd0);
      case (mdop_e'(mdop))
        MDOP_MULT:  {temp_hi_d, temp_lo_d} = prod_s;
        MDOP_MULTU: {temp_hi_d, temp_lo_d} = prod_u;
        MDOP_DIV:   {temp_hi_d, temp_lo_d} = {rem_s, quo_s};
        MDOP_DIVU:  {temp_hi_d, temp_lo_d} = {rem_u, quo_u};
        default: ;
      endcase
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && !div0_q) begin
        hi_d = temp_hi_q;
        lo_d = temp_lo_q;
      end
    end else if (mdop == MDOP_MTHI) begin
      hi_d = A;
    end else if (mdop == MDOP_MTLO) begin
      lo_d = A;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

  always_comb begin
    MDout = '0;
    if (mdop == MDOP_MFHI)      MDout = hi_q;
    else if (mdop == MDOP_MFLO) MDout = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: busy length, HI/LO results,
// MDout muxing, ignored ops while busy, and asynchronous reset mid-run.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, MDout;

  int n_tests = 0;
  int n_fail  = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO), .MDout(MDout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue a start at a falling edge, then count busy cycles until busy drops.
  // With inject set, an mtlo and a second start are presented while busy.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles, input bit inject);
    int cnt;
    start = 1'b1; mdop = op; A = a; B = b;
    cnt = 0;
    for (int guard = 0; guard < 100; guard++) begin
      @(negedge clk);
      start = 1'b0; mdop = MDOP_NONE; A = 32'd0; B = 32'd0;
      if (inject && cnt == 1) begin
        mdop = MDOP_MTLO; A = 32'hDEAD_BEEF;
      end else if (inject && cnt == 2) begin
        start = 1'b1; mdop = MDOP_DIVU; A = 32'd100; B = 32'd3;
      end
      if (!busy) break;
      cnt++;
    end
    start = 1'b0; mdop = MDOP_NONE;
    check({tag, " busy cycles"}, 32'(cnt), 32'(exp_cycles));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdop = MDOP_NONE; A = '0; B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    mdop = MDOP_MFHI; #1;
    check("reset mfhi", MDout, 32'd0);
    mdop = MDOP_NONE;

    run_op("mult", MDOP_MULT, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
    check("mult HI", HI, 32'hFFFF_FFFF);
    check("mult LO", LO, 32'hFFFF_FFFE);
    mdop = MDOP_MFHI; #1;
    check("mfhi", MDout, 32'hFFFF_FFFF);
    mdop = MDOP_MFLO; #1;
    check("mflo", MDout, 32'hFFFF_FFFE);
    mdop = MDOP_NONE; #1;
    check("mdout none", MDout, 32'd0);

    run_op("multu", MDOP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
    check("multu HI", HI, 32'h0000_0001);
    check("multu LO", LO, 32'hFFFF_FFFE);

    run_op("div", MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
    check("div HI", HI, 32'hFFFF_FFFF);
    check("div LO", LO, 32'hFFFF_FFFD);

    run_op("divu", MDOP_DIVU, 32'd7, 32'd2, 10, 1'b0);
    check("divu HI", HI, 32'd1);
    check("divu LO", LO, 32'd3);

    run_op("div ovf", MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
    check("div ovf HI", HI, 32'd0);
    check("div ovf LO", LO, 32'h8000_0000);

    mdop = MDOP_MTHI; A = 32'h1234_5678;
    @(negedge clk);
    mdop = MDOP_NONE; A = '0;
    check("mthi HI", HI, 32'h1234_5678);
    run_op("div0", MDOP_DIV, 32'd55, 32'd0, 10, 1'b0);
    check("div0 HI", HI, 32'h1234_5678);
    check("div0 LO", LO, 32'h8000_0000);

    // Result must not appear before the busy period ends.
    start = 1'b1; mdop = MDOP_MULT; A = 32'd3; B = 32'd5;
    @(negedge clk);
    start = 1'b0; mdop = MDOP_NONE;
    check("early HI", HI, 32'h1234_5678);
    check("early busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);
    check("late HI", HI, 32'd0);
    check("late LO", LO, 32'd15);

    run_op("inject", MDOP_MULT, 32'd6, 32'd7, 5, 1'b1);
    check("inject HI", HI, 32'd0);
    check("inject LO", LO, 32'd42);
    @(negedge clk);
    check("inject idle", {31'd0, busy}, 32'd0);

    start = 1'b1; mdop = MDOP_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; mdop = MDOP_NONE;
    repeat (2) @(negedge clk);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async busy", {31'd0, busy}, 32'd0);
    check("async HI", HI, 32'd0);
    check("async LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post-reset mult", MDOP_MULT, 32'd3, 32'd4, 5, 1'b0);
    check("post-reset HI", HI, 32'd0);
    check("post-reset LO", LO, 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. It sits beside the ALU in E and owns the HI/LO architectural registers. It runs mult/multu/div/divu as multi-cycle operations and raises `busy` so D-stage hazard logic can stall later HI/LO instructions. Its `MDout` result feeds the E→M pipeline register's `MDout_E` input for mfhi/mflo.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy duration of mult/multu.
- `DIV_CYCLES`, 10: busy duration of div/divu.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle pulse from E-stage control when a mult/multu/div/divu is in E.
- `mdop`  in  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
- `A`  in  32  forwarded rs operand.
- `B`  in  32  forwarded rt operand.
- `busy`  out  1  high while an operation is in flight.
- `HI`  out  32  architectural HI.
- `LO`  out  32  architectural LO.
- `MDout`  out  32  combinational: HI when mdop=5, LO when mdop=6, otherwise 0.

## Operation
- Reset (asynchronous): HI=0, LO=0, counter=0, busy=0, result temporaries=0.
- Start is accepted at a rising edge when `start`=1, `busy`=0 and mdop∈{1..4}. On acceptance:
  - Compute the result and latch it into temp_hi/temp_lo.
  - Load the counter with MULT_CYCLES (mdop 1/2) or DIV_CYCLES (mdop 3/4).
- Start is ignored in these cases:
  - `busy`=1. Hazard logic guarantees this does not happen, and the block tolerates it with no state change.
  - mdop outside 1..4.
- mult: signed 32×32→64. multu: unsigned 32×32→64. HI gets bits [63:32] and LO gets bits [31:0].
- div: signed, truncates toward zero. LO=quotient, HI=remainder, with the remainder taking the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned. LO=quotient, HI=remainder.
- Division by zero (B=0): the busy period still runs in full. HI/LO are left unchanged at completion.
- Counter:
  - It decrements by 1 each edge while nonzero.
  - At the edge where it goes 1→0, temp_hi/temp_lo are written to HI/LO, unless the operation was a divide by zero.
  - `busy` = (counter≠0).
- mthi/mtlo (mdop 7/8): write A into HI or LO at the next edge, only when `busy`=0. They are ignored while busy.
- No state machine beyond the IDLE (counter=0) / RUN (counter≠0) split.

## Timing
- Start sampled at the edge ending cycle t. `busy` is high in cycles t+1 … t+N, where N=MULT_CYCLES or DIV_CYCLES.
- HI/LO change at the edge ending cycle t+N. New values are visible and `busy`=0 from cycle t+N+1.
- Hazard logic stalls D on (start | busy) for any HI/LO instruction. The first mfhi after a mult therefore reaches E at cycle t+N+1 at the earliest and reads the new value.
- MDout, HI and LO have zero combinational latency from the registers and mdop.
- A reset asserted mid-RUN clears the counter and HI/LO immediately, and the pending result is discarded. After reset is released, the next start behaves normally.
- A start arriving in the same cycle that busy falls to 0 (cycle t+N+1) is accepted.

## Structure
- Shared definitions header/package: the mdop encodings (MDOP_NONE … MDOP_MTLO), reused by the controller that drives `start`/`mdop` and by the hazard unit.
- Single module. No sub-module is needed: the counter, temporaries and HI/LO live together.
- Products and quotients use behavioral `*`, `/` and `%` with explicit `$signed`/unsigned casts. The 64-bit product is held in a 64-bit wire.

## Test plan
- Reset, then mult with A=0xFFFFFFFF, B=2 → `busy` high for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE. mfhi gives MDout=0xFFFFFFFF.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div with A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2 → LO=3, HI=1.
- mthi with A=0x12345678, then div with B=0 → `busy` high for 10 cycles; HI still 0x12345678 and LO unchanged.
- mult in flight, then mtlo and a second start issued during busy → both ignored; HI/LO equal the mult result only.
- Reset asserted at cycle 3 of a div → busy=0, HI=LO=0 immediately with no clock edge needed. A following mult with A=3, B=4 gives LO=12, HI=0.
